// File: rtl/md5_pkg.sv
// md5_pkg: shared definitions for the MD5 compression engine.
//   md5_state_t : chaining state packed so that A sits in bits [31:0],
//                 B in [63:32], C in [95:64] and D in [127:96].
//   MD5_IV      : standard MD5 initial chaining value.
//   MD5_K       : 64 per-step additive constants.
//   md5_s/g/f   : per-step rotate amount, message word index, round function.
package md5_pkg;

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] c;
    logic [31:0] b;
    logic [31:0] a;
  } md5_state_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} md5_fsm_t;

  localparam md5_state_t MD5_IV = '{d: 32'h10325476, c: 32'h98badcfe,
                                    b: 32'hefcdab89, a: 32'h67452301};

  localparam logic [31:0] MD5_K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Rotate table indexed by {round, step mod 4}.
  localparam logic [4:0] MD5_S [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [4:0] md5_s(input logic [5:0] i);
    return MD5_S[{i[5:4], i[1:0]}];
  endfunction

  // All index formulas are mod 16, so only the low four bits of i matter.
  function automatic logic [3:0] md5_g(input logic [5:0] i);
    logic [3:0] lo;
    logic [3:0] res;
    lo  = i[3:0];
    res = lo;
    case (i[5:4])
      2'd0: res = lo;
      2'd1: res = lo * 4'd5 + 4'd1;
      2'd2: res = lo * 4'd3 + 4'd5;
      2'd3: res = lo * 4'd7;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] md5_f(input logic [5:0] i, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d);
    logic [31:0] res;
    res = b ^ c ^ d;
    case (i[5:4])
      2'd0: res = (b & c) | (~b & d);
      2'd1: res = (d & b) | (~d & c);
      2'd2: res = b ^ c ^ d;
      2'd3: res = c ^ (b | ~d);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/md5_step.sv
// md5_step: one combinational MD5 step.
//   i   : step index 0..63
//   cur : working A..D before the step
//   m   : the 16 message words of the block
//   nxt : working A..D after the step
module md5_step
  import md5_pkg::*;
(
  input  logic [5:0]        i,
  input  md5_state_t        cur,
  input  logic [15:0][31:0] m,
  output md5_state_t        nxt
);

  logic [31:0] f_val;
  logic [31:0] t_val;
  logic [31:0] rot_val;
  logic [4:0]  sh;

  assign f_val = md5_f(i, cur.b, cur.c, cur.d);
  assign t_val = f_val + cur.a + MD5_K[i] + m[md5_g(i)];
  assign sh    = md5_s(i);
  // sh is never zero, so the right shift amount stays within 1..31.
  assign rot_val = (t_val << sh) | (t_val >> (6'd32 - {1'b0, sh}));

  assign nxt = '{a: cur.d, b: cur.b + rot_val, c: cur.b, d: cur.c};

endmodule

// File: rtl/md5_block_engine.sv
// md5_block_engine: iterative MD5 compression of one 512-bit block.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : block handshake; in_block = 16 LE words, in_state = A..D
//   out_valid/out_ready : result handshake; out_state = updated chaining state
//   busy                : high while rounds are being computed
// STEPS_PER_CYCLE (1, 2 or 4) step units are chained per clock.
module md5_block_engine
  import md5_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int S = STEPS_PER_CYCLE;
  localparam logic [5:0] LAST_STEP = 6'(64 - S);

  if (!(S == 1 || S == 2 || S == 4)) begin : g_bad_param
    $error("md5_block_engine: STEPS_PER_CYCLE must be 1, 2 or 4");
  end

  md5_fsm_t          state_reg, state_next;
  logic [5:0]        step_reg;
  logic [15:0][31:0] blk_reg;
  md5_state_t        init_reg;
  md5_state_t        work_reg;
  md5_state_t        out_reg;
  md5_state_t        chain [S+1];
  logic              accept;
  logic              finish;

  assign chain[0] = work_reg;

  for (genvar gi = 0; gi < S; gi++) begin : g_chain
    md5_step u_step (
      .i   (step_reg + 6'(gi)),
      .cur (chain[gi]),
      .m   (blk_reg),
      .nxt (chain[gi+1])
    );
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        // Held low while reset is asserted, even though the FSM is in IDLE.
        in_ready = rst_n;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (step_reg == LAST_STEP) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_reg <= '0;
      blk_reg  <= '0;
      init_reg <= '0;
      work_reg <= '0;
      out_reg  <= '0;
    end else begin
      if (accept) begin
        blk_reg  <= in_block;
        init_reg <= in_state;
        work_reg <= in_state;
        step_reg <= '0;
      end else if (state_reg == RUN) begin
        work_reg <= chain[S];
        // Counter stops at LAST_STEP so it never wraps inside a block.
        if (!finish) step_reg <= step_reg + 6'(S);
      end
      if (finish) begin
        out_reg <= '{a: init_reg.a + chain[S].a, b: init_reg.b + chain[S].b,
                     c: init_reg.c + chain[S].c, d: init_reg.d + chain[S].d};
      end
    end
  end

  assign out_state = out_reg;

endmodule

// File: tb/tb_md5_block_engine.sv
// tb_md5_block_engine: scoreboard bench for md5_block_engine with S = 1, 2, 4.
// Instance k uses STEPS_PER_CYCLE = 1 << k; only one instance is active at a time.
module tb_md5_block_engine;
  import md5_pkg::*;

  localparam logic [127:0] IV_LIT  = 128'h10325476_98badcfe_efcdab89_67452301;
  localparam logic [127:0] EMPTY_D = 128'h7e42f8ec_980980e9_04b2008f_d98c1dd4;
  localparam logic [127:0] ABC_D   = 128'h727fe128_7d3f96d6_b04fd23c_98500190;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   in_valid, in_ready, out_valid, out_ready, busy;
  logic [511:0] in_block [3];
  logic [127:0] in_state [3];
  logic [127:0] out_state [3];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    md5_block_engine #(.STEPS_PER_CYCLE(1 << gi)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .in_block  (in_block[gi]),
      .in_state  (in_state[gi]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi]),
      .out_state (out_state[gi]),
      .busy      (busy[gi])
    );
  end

  typedef struct {
    int           inst;
    logic [127:0] exp;
    int           acc_edge;
    string        name;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_rise [3];
  int   last_hs [3];

  logic [31:0] ref_k [64];
  int ref_sh [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference compression; constants derived from the sine definition.
  function automatic logic [127:0] md5_ref(input logic [127:0] st, input logic [511:0] blk);
    logic [31:0] a, b, c, d, f, tmp, t;
    int g, s;
    a = st[31:0]; b = st[63:32]; c = st[95:64]; d = st[127:96];
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i;              end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      s = ref_sh[(i / 16) * 4 + i % 4];
      t = a + f + ref_k[i] + blk[g*32 +: 32];
      tmp = d; d = c; c = b;
      b = b + ((t << s) | (t >> (32 - s)));
      a = tmp;
    end
    return {d + st[127:96], c + st[95:64], b + st[63:32], a + st[31:0]};
  endfunction

  task automatic send(input int k, input logic [511:0] blk, input logic [127:0] st,
                      input logic [127:0] exp, input string name, input bit push,
                      input bit keep, output int acc);
    in_block[k] = blk;
    in_state[k] = st;
    in_valid[k] = 1'b1;
    acc = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (in_ready[k]) begin
        acc = cyc + 1;
        break;
      end
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL %s accept_timeout: in_ready never seen on inst %0d", name, k);
      in_valid[k] = 1'b0;
      return;
    end
    if (push) sb_q.push_back('{k, exp, acc, name});
    $display("send %s inst=%0d accept_edge=%0d", name, k, acc);
    @(posedge clk); #1;
    if (!keep) in_valid[k] = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s drain_timeout: %0d results pending, required 0", name, sb_q.size());
      sb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Monitor: latency at each out_valid rise, digest at each out handshake.
  initial begin
    logic [2:0] prev_v;
    exp_t e;
    prev_v = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (out_valid[k] && !prev_v[k]) begin
          last_rise[k] = cyc;
          if (sb_q.size() > 0 && sb_q[0].inst == k)
            chk({sb_q[0].name, "_latency"}, 128'(cyc - sb_q[0].acc_edge), 128'(64 >> k));
        end
        if (out_valid[k] && out_ready[k]) begin
          last_hs[k] = cyc + 1;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: inst %0d got %h expected no result", k, out_state[k]);
          end else begin
            e = sb_q.pop_front();
            chk({e.name, "_inst"}, 128'(k), 128'(e.inst));
            chk(e.name, out_state[k], e.exp);
            $display("result %s inst=%0d state=%h", e.name, k, out_state[k]);
          end
        end
      end
      prev_v = out_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] empty_blk, abc_blk, zero_blk;
    logic [127:0] chain_exp;
    int acc, acc2;
    real r;
    longint v;

    for (int i = 0; i < 64; i++) begin
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      v = longint'($floor(r * 4294967296.0));
      ref_k[i] = v[31:0];
    end
    empty_blk = '0;
    empty_blk[31:0] = 32'h00000080;
    abc_blk = '0;
    abc_blk[31:0] = 32'h80636261;
    abc_blk[14*32 +: 32] = 32'h00000018;
    zero_blk = '0;

    rst_n = 1'b0;
    in_valid = '0;
    out_ready = 3'b111;
    for (int k = 0; k < 3; k++) begin
      in_block[k] = '0;
      in_state[k] = '0;
      last_rise[k] = 0;
      last_hs[k] = 0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", 128'(in_ready[k]), 128'(0));
      chk("rst_out_valid", 128'(out_valid[k]), 128'(0));
      chk("rst_busy", 128'(busy[k]), 128'(0));
      chk("rst_out_state", out_state[k], 128'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("post_rst_in_ready", 128'(in_ready[k]), 128'(1));
    @(posedge clk); #1;

    chk("model_empty", md5_ref(IV_LIT, empty_blk), EMPTY_D);
    chk("model_abc", md5_ref(IV_LIT, abc_blk), ABC_D);

    // Known digests; abc on every unroll factor
    send(0, empty_blk, IV_LIT, EMPTY_D, "empty_s1", 1, 0, acc);
    drain("empty_s1");
    for (int k = 0; k < 3; k++) begin
      send(k, abc_blk, IV_LIT, ABC_D, $sformatf("abc_s%0d", 1 << k), 1, 0, acc);
      drain("abc");
    end

    // Backpressure: result held, second block waits for the out handshake
    out_ready[0] = 1'b0;
    send(0, abc_blk, IV_LIT, ABC_D, "bp_abc", 1, 0, acc);
    for (int n = 0; n < 200 && !out_valid[0]; n++) @(negedge clk);
    @(posedge clk); #1;
    fork
      send(0, empty_blk, IV_LIT, EMPTY_D, "bp_second", 1, 0, acc2);
      begin
        for (int n = 0; n < 10; n++) begin
          @(negedge clk);
          chk("bp_out_valid", 128'(out_valid[0]), 128'(1));
          chk("bp_hold_state", out_state[0], ABC_D);
          chk("bp_in_ready", 128'(in_ready[0]), 128'(0));
        end
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
      end
    join
    chk("bp_accept_after_hs", 128'(acc2 - last_hs[0]), 128'(1));
    drain("bp");

    // Abort at step 30, then a clean block
    send(0, abc_blk, IV_LIT, '0, "abort", 0, 0, acc);
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_out_valid", 128'(out_valid[0]), 128'(0));
    chk("abort_busy", 128'(busy[0]), 128'(0));
    chk("abort_out_state", out_state[0], 128'(0));
    chk("abort_in_ready", 128'(in_ready[0]), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", 128'(in_ready[0]), 128'(1));
    @(posedge clk); #1;
    send(0, abc_blk, IV_LIT, ABC_D, "after_abort", 1, 0, acc);
    drain("after_abort");

    // Back-to-back on S=2 with in_valid and out_ready held high
    send(1, empty_blk, IV_LIT, EMPTY_D, "b2b_empty", 1, 1, acc);
    send(1, abc_blk, IV_LIT, ABC_D, "b2b_abc", 1, 0, acc2);
    chk("b2b_gap", 128'(acc2 - last_rise[1]), 128'(2));
    drain("b2b");

    // Chained state through the final wrapping add, on S=4
    chain_exp = md5_ref(ABC_D, zero_blk);
    send(2, zero_blk, ABC_D, chain_exp, "chained", 1, 0, acc);
    drain("chained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md5_block_engine.md
# md5_block_engine

Iterative MD5 compression engine: accepts one 512-bit message block plus a 128-bit chaining state, runs the 64 MD5 steps, and returns the updated chaining state. It sits between the hash generator's padding/block formatter (upstream) and the digest accumulator (downstream). Round constants come from the shared package, not from a standalone lookup module. Throughput is parametrised by the number of steps unrolled per clock.

## Interface
Parameters:
- STEPS_PER_CYCLE, 1, steps computed per clock. Legal values are 1, 2 and 4; any other value is an elaboration-time error.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  in  1  in_block/in_state are valid.
- in_ready  out  1  engine can accept a block.
- in_block  in  512  message words; M[g] = in_block[32g+31:32g], g = 0..15, already little-endian word-assembled.
- in_state  in  128  chaining state; A=[31:0], B=[63:32], C=[95:64], D=[127:96].
- out_valid  out  1  out_state valid.
- out_ready  in  1  downstream accepts out_state.
- out_state  out  128  updated chaining state, same packing as in_state.
- busy  out  1  high while in the RUN state.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_block, in_state and working copies A..D, clear step counter i, and go to RUN.
  - RUN: each cycle, apply STEPS_PER_CYCLE chained steps (i .. i+S-1) and set i += S. After the cycle that computes step 63, add the working A..D word-wise (mod 2^32) to the latched in_state, register the result into out_state, and go to DONE.
  - DONE: out_valid=1 and out_state held stable. On out_ready, go to IDLE.
- Step i, with B,C,D the current working words:
  - 0–15: f=(B&C)|(~B&D), g=i, shifts 7,12,17,22.
  - 16–31: f=(D&B)|(~D&C), g=(5i+1) mod 16, shifts 5,9,14,20.
  - 32–47: f=B^C^D, g=(3i+5) mod 16, shifts 4,11,16,23.
  - 48–63: f=C^(B|~D), g=7i mod 16, shifts 6,10,15,21.
  - Shift amount is shifts[i mod 4].
  - t = f+A+K[i]+M[g] (mod 2^32). Then A←D, D←C, C←B, B←B+rotl(t,s).
- All additions are 32-bit, wrapping, with no carry out.
- in_block and in_state are ignored outside the accept cycle.
- The step counter is 6 bits and never wraps within a block; the exit condition is i == 64−S.

## Timing
- Reset values: in_ready=0 during reset, 1 in the first cycle after reset. out_valid=0, busy=0, out_state=0, FSM=IDLE, counter=0.
- Accept at edge t. busy is high for cycles t .. t+64/S−1. out_valid rises at edge t+64/S, so latency is 64, 32 or 16 cycles for S = 1, 2, 4.
- out_ready already high when out_valid rises: the handshake completes in that single cycle, and in_ready=1 on the next cycle. No same-cycle bypass from DONE to accept.
- out_ready low: out_valid and out_state hold indefinitely. in_ready stays 0.
- rst_n low in any state, including mid-RUN or DONE: the block is aborted and all outputs return to their reset values on that edge. No partial result is ever emitted.
- in_valid asserted while not IDLE: ignored. Upstream must hold it until in_ready.

## Structure
- Package md5_pkg holds:
  - the 64-entry K constant array;
  - shift-amount function s(i);
  - message-index function g(i);
  - round-function f(i,B,C,D);
  - the state packing typedef (struct of four 32-bit words A, B, C, D);
  - the MD5 IV constant.
- Sub-module md5_step: purely combinational, one step. Inputs are i, A..D and the 16 message words; outputs are next A..D. The engine instantiates STEPS_PER_CYCLE copies in a chain with indices i+0 .. i+S−1.

## Test plan
- Empty string: M0=0x00000080, M1..15=0, in_state=IV (67452301, efcdab89, 98badcfe, 10325476) → out_state A=d98c1dd4, B=04b2008f, C=980980e9, D=7e42f8ec.
- "abc": M0=0x80636261, M14=0x00000018, others 0, IV → A=98500190, B=b04fd23c, C=7d3f96d6, D=727fe128. Repeat for S = 1, 2, 4 and check latency is exactly 64, 32 and 16 cycles.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. out_state must stay stable, in_ready must stay 0, and the second in_valid must be accepted only after the out handshake.
- Reset at step 30 of a RUN: all outputs return to reset values. A following "abc" block must produce the correct digest.
- Back-to-back: keep in_valid and out_ready permanently high with alternating empty/"abc" blocks. Both digests must be correct, with exactly one idle cycle between out_valid and the next busy.
- Chained state: feed the "abc" output as in_state with an all-zero block. The result must match the golden model, exercising mod-2^32 wrap in the final add.
